// File: rtl/ex_mem_pipe_buf.sv
// ex_mem_pipe_buf: elastic EX/MEM pipeline register with a two-entry skid buffer.
// The main register drives the outputs. The skid register catches the beat that
// arrives in the same cycle the memory stage stalls. flush squashes everything
// held and inserts a bubble. out_ctrl is gated so an empty slot never writes.
// Optional forwarding-match outputs are built when EX_MEM_FWD_EN is defined.
module ex_mem_pipe_buf #(
   parameter int DATA_W = 32,
   parameter int AW_W   = 5,
   parameter int CTRL_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_res,
   input  logic [DATA_W-1:0] in_dw,
   input  logic [DATA_W-1:0] in_add2,
   input  logic [AW_W-1:0]   in_aw,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_res,
   output logic [DATA_W-1:0] out_dw,
   output logic [DATA_W-1:0] out_add2,
   output logic [AW_W-1:0]   out_aw,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        level
`ifdef EX_MEM_FWD_EN
   ,
   input  logic [AW_W-1:0]   fwd_rs,
   input  logic [AW_W-1:0]   fwd_rt,
   output logic              fwd_a,
   output logic              fwd_b
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] res;
      logic [DATA_W-1:0] dw;
      logic [DATA_W-1:0] add2;
      logic [AW_W-1:0]   aw;
      logic [CTRL_W-1:0] ctrl;
   } beat_t;

   // Encoding doubles as the occupancy count driven onto level.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;
   beat_t  main_q, main_d;
   beat_t  skid_q, skid_d;
   beat_t  in_beat;
   logic   accept, drain;

   assign in_beat   = '{res: in_res, dw: in_dw, add2: in_add2, aw: in_aw, ctrl: in_ctrl};
   // in_ready comes from registered state only, so out_ready never reaches it.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;
   assign level     = state_q;

   assign out_res  = main_q.res;
   assign out_dw   = main_q.dw;
   assign out_add2 = main_q.add2;
   assign out_aw   = main_q.aw;
   // Bubble: no control bit may assert for an empty slot.
   assign out_ctrl = out_valid ? main_q.ctrl : '0;

   // Next-state and payload steering; flush overrides and discards any accept.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = in_beat;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_d = in_beat;
            end else if (accept) begin
               skid_d  = in_beat;
               state_d = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   // State and payload registers; reset clears everything so outputs read zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef EX_MEM_FWD_EN
   // Match against the instruction now in execute; register 0 never forwards.
   assign fwd_a = out_valid & out_ctrl[0] & (out_aw != '0) & (out_aw == fwd_rs);
   assign fwd_b = out_valid & out_ctrl[0] & (out_aw != '0) & (out_aw == fwd_rt);
`endif

endmodule

// File: tb/tb_ex_mem_pipe_buf.sv
// Directed bench for ex_mem_pipe_buf: reset, latency, backpressure ordering,
// flush, asynchronous reset mid-transfer and (with EX_MEM_FWD_EN) forwarding.
module tb_ex_mem_pipe_buf;
   localparam int DATA_W = 32;
   localparam int AW_W   = 5;
   localparam int CTRL_W = 6;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_res, in_dw, in_add2, out_res, out_dw, out_add2;
   logic [AW_W-1:0]   in_aw, out_aw;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [1:0]        level;
`ifdef EX_MEM_FWD_EN
   logic [AW_W-1:0]   fwd_rs, fwd_rt;
   logic              fwd_a, fwd_b;
`endif

   int checks   = 0;
   int failures = 0;

   ex_mem_pipe_buf #(.DATA_W(DATA_W), .AW_W(AW_W), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_res(in_res), .in_dw(in_dw), .in_add2(in_add2),
      .in_aw(in_aw), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_dw(out_dw), .out_add2(out_add2),
      .out_aw(out_aw), .out_ctrl(out_ctrl), .level(level)
`ifdef EX_MEM_FWD_EN
      , .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [31:0] r, input logic [4:0] a, input logic [5:0] c);
      in_valid = v;
      in_res   = r;
      in_dw    = ~r;
      in_add2  = r + 32'd4;
      in_aw    = a;
      in_ctrl  = c;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      beat(1'b0, 32'd0, 5'd0, 6'd0);
`ifdef EX_MEM_FWD_EN
      fwd_rs = '0; fwd_rt = '0;
`endif
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_res", out_res, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      step(); step();
      rst = 1'b0;

      // Single beat latency
      beat(1'b1, 32'h0000_1234, 5'd5, 6'b000001);
      out_ready = 1'b1;
      step();
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_res", out_res, 32'h0000_1234);
      chk("lat_out_dw", out_dw, 32'hFFFF_EDCB);
      chk("lat_out_add2", out_add2, 32'h0000_1238);
      chk("lat_out_aw", out_aw, 5);
      chk("lat_out_ctrl", out_ctrl, 1);
      chk("lat_level", level, 1);
      beat(1'b0, 32'd0, 5'd0, 6'd0);
      step();
      chk("drain_level", level, 0);
      chk("drain_out_ctrl", out_ctrl, 0);

      // Backpressure: 4 beats, out_ready low
      out_ready = 1'b0;
      beat(1'b1, 32'hA1, 5'd1, 6'b000011);
      step();
      chk("bp1_level", level, 1);
      chk("bp1_res", out_res, 32'hA1);
      chk("bp1_in_ready", in_ready, 1);
      beat(1'b1, 32'hA2, 5'd2, 6'b000001);
      step();
      chk("bp2_level", level, 2);
      chk("bp2_in_ready", in_ready, 0);
      chk("bp2_res", out_res, 32'hA1);
      beat(1'b1, 32'hA3, 5'd3, 6'b000001);
      step();
      chk("bp3_level", level, 2);
      chk("bp3_res", out_res, 32'hA1);
      chk("bp3_ctrl", out_ctrl, 6'b000011);
      out_ready = 1'b1;
      step();
      chk("rel1_res", out_res, 32'hA2);
      chk("rel1_aw", out_aw, 2);
      chk("rel1_level", level, 1);
      chk("rel1_in_ready", in_ready, 1);
      step();
      chk("rel2_res", out_res, 32'hA3);
      chk("rel2_level", level, 1);
      beat(1'b1, 32'hA4, 5'd4, 6'b000001);
      step();
      chk("rel3_res", out_res, 32'hA4);
      chk("rel3_level", level, 1);
      beat(1'b0, 32'd0, 5'd0, 6'd0);
      step();
      chk("rel4_level", level, 0);
      chk("rel4_out_valid", out_valid, 0);

      // Flush at level 2
      out_ready = 1'b0;
      beat(1'b1, 32'hB1, 5'd9, 6'b001001);
      step();
      beat(1'b1, 32'hB2, 5'd10, 6'b001001);
      step();
      chk("fl_pre_level", level, 2);
      flush = 1'b1;
      beat(1'b1, 32'hB3, 5'd11, 6'b001001);
      step();
      chk("fl_level", level, 0);
      chk("fl_out_valid", out_valid, 0);
      chk("fl_out_ctrl", out_ctrl, 0);
      chk("fl_in_ready", in_ready, 1);
      flush = 1'b0;
      beat(1'b0, 32'd0, 5'd0, 6'd0);
      out_ready = 1'b1;
      step();
      chk("fl_post_out_valid", out_valid, 0);
      chk("fl_post_level", level, 0);

      // Async reset mid-transfer at level 2
      out_ready = 1'b0;
      beat(1'b1, 32'hC1, 5'd12, 6'b011001);
      step();
      beat(1'b1, 32'hC2, 5'd13, 6'b011001);
      step();
      beat(1'b0, 32'd0, 5'd0, 6'd0);
      chk("ar_pre_level", level, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_level", level, 0);
      chk("ar_in_ready", in_ready, 1);
      chk("ar_out_res", out_res, 0);
      chk("ar_out_aw", out_aw, 0);
      chk("ar_out_ctrl", out_ctrl, 0);
      step();
      rst = 1'b0;

`ifdef EX_MEM_FWD_EN
      out_ready = 1'b0;
      beat(1'b1, 32'hD1, 5'd7, 6'b000001);
      step();
      beat(1'b0, 32'd0, 5'd0, 6'd0);
      fwd_rs = 5'd7; fwd_rt = 5'd3;
      #1;
      chk("fwd_a_hit", fwd_a, 1);
      chk("fwd_b_miss", fwd_b, 0);
      out_ready = 1'b1;
      beat(1'b1, 32'hD2, 5'd0, 6'b000001);
      step();
      fwd_rs = 5'd0;
      #1;
      chk("fwd_a_r0", fwd_a, 0);
      beat(1'b1, 32'hD3, 5'd7, 6'b000000);
      step();
      fwd_rs = 5'd7;
      #1;
      chk("fwd_a_norw", fwd_a, 0);
      beat(1'b0, 32'd0, 5'd0, 6'd0);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
